// File: rtl/axi_mem_slave.sv
// Parametrised AXI4 memory target: single-ported, one transaction at a time,
// FIXED/INCR/WRAP bursts, per-beat SLVERR and round-robin AR/AW arbitration.
module axi_mem_slave #(
    parameter int               DATA_W = 32,
    parameter int               ADDR_W = 32,
    parameter int               ID_W   = 4,
    parameter int               DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE  = 32'h8000_0000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [ID_W-1:0]     arid_i,
    input  logic [ADDR_W-1:0]   araddr_i,
    input  logic [7:0]          arlen_i,
    input  logic [2:0]          arsize_i,
    input  logic [1:0]          arburst_i,
    input  logic                arvalid_i,
    output logic                arready_o,
    output logic [ID_W-1:0]     rid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic [7:0]          awlen_i,
    input  logic [2:0]          awsize_i,
    input  logic [1:0]          awburst_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam int AW_LSB = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + (ADDR_W+1)'(DEPTH * STRB_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WRESP = 2'd3;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        state_q;
    logic              prio_q;     // 0: read wins a tie, 1: write wins
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        cnt_q;
    logic              err_q;
    logic              over_q;     // write beats past len, discarded until wlast
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz,
                                                    input logic [1:0] bt,
                                                    input logic [7:0] ln);
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] wmask;
        inc   = ADDR_W'(1) << sz;
        wmask = ((ADDR_W'(ln) + ADDR_W'(1)) << sz) - ADDR_W'(1);
        case (bt)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~wmask) | ((a + inc) & wmask);
            default: next_addr = a + inc;
        endcase
    endfunction

    function automatic logic beat_err(input logic [ADDR_W-1:0] a,
                                      input logic [2:0] sz,
                                      input logic [1:0] bt,
                                      input logic [7:0] ln);
        logic cfg_bad;
        logic rng_bad;
        cfg_bad = (sz > 3'(AW_LSB)) || (bt == 2'b11) ||
                  ((bt == 2'b10) && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15));
        rng_bad = ({1'b0, a} < {1'b0, BASE}) || ({1'b0, a} >= LIMIT);
        beat_err = cfg_bad || rng_bad;
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
        widx = IDX_W'((a - BASE) >> AW_LSB);
    endfunction

    logic              ar_win, aw_win;
    logic [ADDR_W-1:0] nxt_addr, ld_addr;
    logic              ld_err, w_err, mem_we;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        ar_win    = arvalid_i && (!awvalid_i || !prio_q);
        aw_win    = awvalid_i && (!arvalid_i || prio_q);
        arready_o = rst_n_i && (state_q == S_IDLE) && ar_win;
        awready_o = rst_n_i && (state_q == S_IDLE) && aw_win;
        wready_o  = rst_n_i && (state_q == S_WRITE);
        nxt_addr  = next_addr(addr_q, size_q, burst_q, len_q);
        // Beat 0 is fetched straight from the AR channel so rvalid rises one cycle after the handshake.
        if (state_q == S_IDLE) begin
            ld_addr = araddr_i;
            ld_err  = beat_err(araddr_i, arsize_i, arburst_i, arlen_i);
        end else begin
            ld_addr = nxt_addr;
            ld_err  = beat_err(nxt_addr, size_q, burst_q, len_q);
        end
        ld_data = ld_err ? '0 : mem_q[widx(ld_addr)];
        w_err   = beat_err(addr_q, size_q, burst_q, len_q);
        mem_we  = rst_n_i && (state_q == S_WRITE) && wvalid_i && !over_q && !w_err;
    end

    assign rid_o    = id_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;
    assign rvalid_o = rvalid_q;
    assign bid_o    = id_q;
    assign bresp_o  = bresp_q;
    assign bvalid_o = bvalid_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++)
            if (mem_we && wstrb_i[b])
                mem_q[widx(addr_q)][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            over_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            rlast_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arvalid_i && awvalid_i)
                        prio_q <= !prio_q;
                    if (arready_o) begin
                        state_q  <= S_READ;
                        id_q     <= arid_i;
                        addr_q   <= araddr_i;
                        len_q    <= arlen_i;
                        size_q   <= arsize_i;
                        burst_q  <= arburst_i;
                        cnt_q    <= '0;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_err ? SLVERR : OKAY;
                        rlast_q  <= (arlen_i == 8'd0);
                    end else if (awready_o) begin
                        state_q  <= S_WRITE;
                        id_q     <= awid_i;
                        addr_q   <= awaddr_i;
                        len_q    <= awlen_i;
                        size_q   <= awsize_i;
                        burst_q  <= awburst_i;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        over_q   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (rready_i) begin
                        if (rlast_q) begin
                            state_q  <= S_IDLE;
                            rvalid_q <= 1'b0;
                            rdata_q  <= '0;
                            rresp_q  <= OKAY;
                            rlast_q  <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            addr_q  <= nxt_addr;
                            rdata_q <= ld_data;
                            rresp_q <= ld_err ? SLVERR : OKAY;
                            rlast_q <= (cnt_q + 8'd1 == len_q);
                        end
                    end
                end
                S_WRITE: begin
                    if (wvalid_i) begin
                        if (wlast_i) begin
                            state_q  <= S_WRESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || (!over_q && w_err) || over_q || (cnt_q != len_q))
                                        ? SLVERR : OKAY;
                        end else begin
                            err_q  <= err_q || (!over_q && w_err);
                            over_q <= over_q || (cnt_q == len_q);
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= nxt_addr;
                        end
                    end
                end
                default: begin
                    if (bready_i) begin
                        state_q  <= S_IDLE;
                        bvalid_q <= 1'b0;
                        bresp_q  <= OKAY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: table of single-beat transactions plus
// hand-written burst, arbitration, error and reset sequences.
module tb_axi_mem_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk, rst_n;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_d [16];
    logic [31:0] wd [16];

    axi_mem_slave dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
        .wready_o(wready), .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid),
        .bready_i(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t tv [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic ar_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        arid = id; araddr = a; arlen = ln; arsize = sz; arburst = bt; arvalid = 1'b1;
        #1;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        check("arready", {63'b0, arready}, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic aw_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bt);
        int n = 0;
        awid = id; awaddr = a; awlen = ln; awsize = sz; awburst = bt; awvalid = 1'b1;
        #1;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        check("awready", {63'b0, awready}, 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        #1;
        while (!wready && n < 20) begin @(negedge clk); #1; n++; end
        check("wready", {63'b0, wready}, 64'd1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_chk(input string nm, input logic [1:0] er, input logic [3:0] eid);
        int n = 0;
        bready = 1'b1;
        #1;
        while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
        check({nm, "_bvalid"}, {63'b0, bvalid}, 64'd1);
        check({nm, "_bresp"}, {62'b0, bresp}, {62'b0, er});
        check({nm, "_bid"}, {60'b0, bid}, {60'b0, eid});
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic r_chk(input string nm, input logic [31:0] ed, input logic [1:0] er,
                         input logic el, input logic [3:0] eid);
        int n = 0;
        rready = 1'b1;
        #1;
        while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
        check({nm, "_rvalid"}, {63'b0, rvalid}, 64'd1);
        check({nm, "_rdata"}, {32'b0, rdata}, {32'b0, ed});
        check({nm, "_rresp"}, {62'b0, rresp}, {62'b0, er});
        check({nm, "_rlast"}, {63'b0, rlast}, {63'b0, el});
        check({nm, "_rid"}, {60'b0, rid}, {60'b0, eid});
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Reads n beats against exp_d; with stall set, each beat is held one cycle first.
    task automatic rd_burst(input string nm, input int nb, input bit stall, input logic [3:0] eid);
        logic [31:0] hd;
        logic        hl;
        for (int b = 0; b < nb; b++) begin
            if (stall) begin
                int n = 0;
                rready = 1'b0;
                #1;
                while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
                hd = rdata; hl = rlast;
                @(negedge clk); #1;
                check($sformatf("%s_hold%0d", nm, b), {31'b0, rvalid, rlast, rdata},
                      {31'b0, 1'b1, hl, hd});
            end
            r_chk($sformatf("%s_b%0d", nm, b), exp_d[b], 2'b00, b == nb - 1, eid);
        end
    endtask

    function automatic logic [63:0] all_out();
        all_out = {14'b0, arready, rid, rdata, rresp, rlast, rvalid, awready, wready,
                   bid, bresp, bvalid};
    endfunction

    initial begin
        rst_n = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;

        tv[0]  = '{1'b1, 4'h3, BASE + 32'h8,    3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00};
        tv[1]  = '{1'b0, 4'h5, BASE + 32'h8,    3'd2, 2'b01, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        tv[2]  = '{1'b1, 4'h1, BASE + 32'h20,   3'd2, 2'b01, 32'h11223344, 4'hF, 32'h0,        2'b00};
        tv[3]  = '{1'b1, 4'h2, BASE + 32'h20,   3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
        tv[4]  = '{1'b0, 4'h2, BASE + 32'h20,   3'd2, 2'b01, 32'h0,        4'h0, 32'h11BB33DD, 2'b00};
        tv[5]  = '{1'b0, 4'h7, BASE + 32'h1000, 3'd2, 2'b01, 32'h0,        4'h0, 32'h0,        2'b10};
        tv[6]  = '{1'b1, 4'h4, BASE + 32'h1000, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        tv[7]  = '{1'b0, 4'h0, BASE - 32'h4,    3'd2, 2'b01, 32'h0,        4'h0, 32'h0,        2'b10};
        tv[8]  = '{1'b1, 4'h6, BASE + 32'h30,   3'd2, 2'b01, 32'h5555AAAA, 4'hF, 32'h0,        2'b00};
        tv[9]  = '{1'b1, 4'h6, BASE + 32'h30,   3'd3, 2'b01, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10};
        tv[10] = '{1'b0, 4'h9, BASE + 32'h30,   3'd2, 2'b01, 32'h0,        4'h0, 32'h5555AAAA, 2'b00};
        tv[11] = '{1'b0, 4'hA, BASE + 32'h8,    3'd2, 2'b11, 32'h0,        4'h0, 32'h0,        2'b10};
        tv[12] = '{1'b0, 4'hF, BASE + 32'hA,    3'd0, 2'b01, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
        tv[13] = '{1'b1, 4'hE, BASE + 32'hFFC,  3'd2, 2'b01, 32'h0BADF00D, 4'hF, 32'h0,        2'b00};
        tv[14] = '{1'b0, 4'hE, BASE + 32'hFFC,  3'd2, 2'b01, 32'h0,        4'h0, 32'h0BADF00D, 2'b00};
        tv[15] = '{1'b0, 4'hC, BASE + 32'h8,    3'd2, 2'b10, 32'h0,        4'h0, 32'h0,        2'b10};

        repeat (2) @(negedge clk);
        #1 check("rst_out", all_out(), 64'd0);
        arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (tv[i].wr) begin
                aw_req(tv[i].id, tv[i].addr, 8'd0, tv[i].size, tv[i].burst);
                w_beat(tv[i].data, tv[i].strb, 1'b1);
                b_chk($sformatf("vec%0d", i), tv[i].exp_resp, tv[i].id);
            end else begin
                ar_req(tv[i].id, tv[i].addr, 8'd0, tv[i].size, tv[i].burst);
                #1 check($sformatf("vec%0d_lat", i), {63'b0, rvalid}, 64'd1);
                r_chk($sformatf("vec%0d", i), tv[i].exp_data, tv[i].exp_resp, 1'b1, tv[i].id);
            end
        end

        // INCR len 3, read back with rready toggling
        for (int b = 0; b < 4; b++) wd[b] = 32'h1000_0000 + 32'(b);
        aw_req(4'h1, BASE + 32'h40, 8'd3, 3'd2, 2'b01);
        for (int b = 0; b < 4; b++) w_beat(wd[b], 4'hF, b == 3);
        b_chk("incr_w", 2'b00, 4'h1);
        for (int b = 0; b < 4; b++) exp_d[b] = wd[b];
        ar_req(4'h2, BASE + 32'h40, 8'd3, 3'd2, 2'b01);
        rd_burst("incr_r", 4, 1'b1, 4'h2);

        // WRAP len 3 from 0x18 visits 0x18, 0x1C, 0x10, 0x14
        for (int b = 0; b < 4; b++) wd[b] = 32'h2000_0000 + 32'(b);
        aw_req(4'h3, BASE + 32'h10, 8'd3, 3'd2, 2'b01);
        for (int b = 0; b < 4; b++) w_beat(wd[b], 4'hF, b == 3);
        b_chk("wrap_w", 2'b00, 4'h3);
        exp_d[0] = wd[2]; exp_d[1] = wd[3]; exp_d[2] = wd[0]; exp_d[3] = wd[1];
        ar_req(4'h4, BASE + 32'h18, 8'd3, 3'd2, 2'b10);
        rd_burst("wrap_r", 4, 1'b0, 4'h4);

        // FIXED len 3: only the last beat survives
        aw_req(4'h5, BASE + 32'h50, 8'd3, 3'd2, 2'b00);
        for (int b = 0; b < 4; b++) w_beat(32'hC000_0000 + 32'(b), 4'hF, b == 3);
        b_chk("fixed_w", 2'b00, 4'h5);
        ar_req(4'h5, BASE + 32'h50, 8'd0, 3'd2, 2'b01);
        r_chk("fixed_r", 32'hC000_0003, 2'b00, 1'b1, 4'h5);

        // Early wlast and overlong burst both give SLVERR
        aw_req(4'h6, BASE + 32'h60, 8'd3, 3'd2, 2'b01);
        w_beat(32'h6060_0000, 4'hF, 1'b0);
        w_beat(32'h6060_0001, 4'hF, 1'b1);
        b_chk("early_wlast", 2'b10, 4'h6);
        aw_req(4'h7, BASE + 32'h68, 8'd0, 3'd2, 2'b01);
        w_beat(32'h6868_0000, 4'hF, 1'b0);
        w_beat(32'h6868_0001, 4'hF, 1'b1);
        b_chk("over_wlast", 2'b10, 4'h7);
        ar_req(4'h7, BASE + 32'h68, 8'd0, 3'd2, 2'b01);
        r_chk("over_r", 32'h6868_0000, 2'b00, 1'b1, 4'h7);

        // Arbitration: simultaneous valids grant read, write, read
        arid = 4'h1; araddr = BASE + 32'h8; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
        awid = 4'h2; awaddr = BASE + 32'h70; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
        arvalid = 1'b1; awvalid = 1'b1;
        #1 check("arb_g1", {62'b0, arready, awready}, 64'b10);
        @(negedge clk);
        araddr = BASE + 32'h20;
        r_chk("arb_r1", 32'hDEADBEEF, 2'b00, 1'b1, 4'h1);
        #1 check("arb_g2", {62'b0, arready, awready}, 64'b01);
        @(negedge clk);
        awaddr = BASE + 32'h74;
        w_beat(32'h7777_0000, 4'hF, 1'b1);
        b_chk("arb_b1", 2'b00, 4'h2);
        #1 check("arb_g3", {62'b0, arready, awready}, 64'b10);
        @(negedge clk);
        arvalid = 1'b0;
        r_chk("arb_r2", 32'h11BB33DD, 2'b00, 1'b1, 4'h1);
        #1 check("arb_g4", {62'b0, arready, awready}, 64'b01);
        @(negedge clk);
        awvalid = 1'b0;
        w_beat(32'h7777_0001, 4'hF, 1'b1);
        b_chk("arb_b2", 2'b00, 4'h2);
        ar_req(4'h8, BASE + 32'h70, 8'd1, 3'd2, 2'b01);
        exp_d[0] = 32'h7777_0000; exp_d[1] = 32'h7777_0001;
        rd_burst("arb_rb", 2, 1'b0, 4'h8);

        // Reset during beat 2 of a read burst
        ar_req(4'h9, BASE + 32'h40, 8'd3, 3'd2, 2'b01);
        r_chk("mrst_b0", 32'h1000_0000, 2'b00, 1'b0, 4'h9);
        r_chk("mrst_b1", 32'h1000_0001, 2'b00, 1'b0, 4'h9);
        rst_n = 1'b0;
        @(negedge clk);
        #1 check("mrst_out", all_out(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        ar_req(4'hB, BASE + 32'h40, 8'd0, 3'd2, 2'b01);
        #1 check("mrst_lat", {63'b0, rvalid}, 64'd1);
        r_chk("mrst_fresh", 32'h1000_0000, 2'b00, 1'b1, 4'hB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
